// File: rtl/xbar_pkg.sv
// Shared constants and types for the crossbar serial receive path.
// Optional build macro used by this slice: RX_FRAME_CHECK_EN.
package xbar_pkg;

    localparam int ports        = 4;
    localparam int packet_width = 8;

    typedef logic [packet_width-1:0] packet;

    // One start bit, packet_width data bits, one stop bit.
    localparam int FRAME = packet_width + 2;

endpackage

// File: rtl/xbar_rx_lane.sv
// One serial lane: shift register, word capture on the strobe, and an
// optional start/stop check enabled by RX_FRAME_CHECK_EN.
module xbar_rx_lane
    import xbar_pkg::*;
#(
    parameter int PACKET_WIDTH = packet_width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk10,
    input  logic                    serial_in,
    output logic [PACKET_WIDTH-1:0] data,
    output logic                    data_vld
`ifdef RX_FRAME_CHECK_EN
    ,
    output logic                    frame_err
`endif
);

    // Start bit plus data bits; the stop bit is on the line during the strobe cycle.
    logic [PACKET_WIDTH:0]   r_sh;
    logic [PACKET_WIDTH-1:0] r_data;
    logic                    r_vld;

    // Shift every cycle; reset refills with idle ones so a partial frame after release reads as 1s.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '1;
        end else begin
            r_sh <= {r_sh[PACKET_WIDTH-1:0], serial_in};
        end
    end

    // Capture the data bits preceding the stop bit on each strobe; clk10 is ignored during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (clk10) begin
            r_data <= r_sh[PACKET_WIDTH-1:0];
            r_vld  <= 1'b1;
        end else begin
            r_vld  <= 1'b0;
        end
    end

`ifdef RX_FRAME_CHECK_EN
    logic r_frame_err;

    // Flag a non-zero start bit or a non-one stop bit; data still updates on error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (clk10) begin
            r_frame_err <= r_sh[PACKET_WIDTH] | ~serial_in;
        end
    end

    assign frame_err = r_frame_err;
`endif

    assign data     = r_data;
    assign data_vld = r_vld;

endmodule

// File: rtl/xbar_serial_receiver.sv
// Crossbar output-side deserializer: PORTS independent serial lanes, all
// frame-aligned to the clk10 word strobe, presented together on data.
// Valid/ready note: there is no ready; data_vld is a one-cycle pulse in the
// cycle data changes, and data holds until the next strobe.
// Optional build macro: RX_FRAME_CHECK_EN adds the frame_err output.
module xbar_serial_receiver
    import xbar_pkg::*;
#(
    parameter int PORTS        = ports,
    parameter int PACKET_WIDTH = packet_width
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk10,
    input  logic [PORTS-1:0]              serial_in,
    output logic [PORTS*PACKET_WIDTH-1:0] data,
    output logic                          data_vld
`ifdef RX_FRAME_CHECK_EN
    ,
    output logic [PORTS-1:0]              frame_err
`endif
);

    logic [PORTS-1:0] w_lane_vld;

    // One lane per port; all lanes share the strobe and reset so they update together.
    for (genvar g = 0; g < PORTS; g++) begin : g_lane
        xbar_rx_lane #(
            .PACKET_WIDTH (PACKET_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clk10     (clk10),
            .serial_in (serial_in[g]),
            .data      (data[g*PACKET_WIDTH +: PACKET_WIDTH]),
            .data_vld  (w_lane_vld[g])
`ifdef RX_FRAME_CHECK_EN
            ,
            .frame_err (frame_err[g])
`endif
        );
    end

    // Lanes pulse in lockstep, so the combined strobe is simply their AND.
    assign data_vld = &w_lane_vld;

endmodule

// File: tb/tb_xbar_serial_receiver.sv
// Directed bench for xbar_serial_receiver (4 lanes x 8 bits).
// Compile with +define+RX_FRAME_CHECK_EN to also exercise frame_err.
module tb_xbar_serial_receiver;
    import xbar_pkg::*;

    logic        clk;
    logic        rst;
    logic        clk10;
    logic [3:0]  serial_in;
    logic [31:0] data;
    logic        data_vld;
`ifdef RX_FRAME_CHECK_EN
    logic [3:0]  frame_err;
`endif

    int n_cmp;
    int n_err;

    xbar_serial_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .clk10     (clk10),
        .serial_in (serial_in),
        .data      (data),
        .data_vld  (data_vld)
`ifdef RX_FRAME_CHECK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    // Clock and reset-state block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs at a negedge, return at the next negedge (after the posedge used them).
    task automatic drive_cycle(input logic [3:0] s, input logic strobe, input logic r);
        serial_in = s;
        clk10     = strobe;
        rst       = r;
        @(negedge clk);
    endtask

    // One full frame on the active lanes (others idle high); strobe on the stop-bit cycle.
    task automatic send_frame(input logic [31:0] words, input logic [3:0] active, input logic [3:0] stop);
        logic [3:0] s;
        for (int b = 0; b < FRAME; b++) begin
            for (int l = 0; l < 4; l++) begin
                if (!active[l])        s[l] = 1'b1;
                else if (b == 0)       s[l] = 1'b0;
                else if (b == FRAME-1) s[l] = stop[l];
                else                   s[l] = words[l*8 + (8 - b)];
            end
            drive_cycle(s, (b == FRAME-1), 1'b0);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        clk10     = 1'b0;
        serial_in = 4'hF;
        @(negedge clk);

        // Reset with toggling lines and a strobe pulse.
        for (int c = 0; c < 3; c++) begin
            drive_cycle(c[0] ? 4'b1010 : 4'b0101, (c == 1), 1'b1);
            check("rst_data", data, 32'h0);
            check("rst_vld", {31'b0, data_vld}, 32'h0);
`ifdef RX_FRAME_CHECK_EN
            check("rst_ferr", {28'b0, frame_err}, 32'h0);
`endif
        end
        drive_cycle(4'hF, 1'b0, 1'b0);
        check("idle_data", data, 32'h0);

        // Single word on lane 0; other lanes idle so they capture all ones.
        send_frame(32'h0000_00A5, 4'b0001, 4'hF);
        check("single_data", data, 32'hFFFF_FFA5);
        check("single_vld", {31'b0, data_vld}, 32'h1);
        drive_cycle(4'hF, 1'b0, 1'b0);
        check("single_vld_drop", {31'b0, data_vld}, 32'h0);
        check("single_hold", data, 32'hFFFF_FFA5);

        // Distinct words on every lane, then hold for 9 cycles.
        send_frame(32'h00FF_8001, 4'hF, 4'hF);
        check("multi_data", data, 32'h00FF_8001);
        check("multi_vld", {31'b0, data_vld}, 32'h1);
        for (int c = 0; c < 9; c++) begin
            drive_cycle(4'hF, 1'b0, 1'b0);
            check("multi_hold", data, 32'h00FF_8001);
            check("multi_hold_vld", {31'b0, data_vld}, 32'h0);
        end

        // Header then payload, frames back to back.
        send_frame(32'h0303_0303, 4'hF, 4'hF);
        check("hdr_data", data, 32'h0303_0303);
        check("hdr_vld", {31'b0, data_vld}, 32'h1);
        send_frame(32'h5C5C_5C5C, 4'hF, 4'hF);
        check("pay_data", data, 32'h5C5C_5C5C);
        check("pay_vld", {31'b0, data_vld}, 32'h1);

        // Reset at data bit 4 (cycle 4 of frame 8'hAA), then a clean frame.
        drive_cycle(4'h0, 1'b0, 1'b0);
        drive_cycle(4'hF, 1'b0, 1'b0);
        drive_cycle(4'h0, 1'b0, 1'b0);
        drive_cycle(4'hF, 1'b0, 1'b0);
        drive_cycle(4'h0, 1'b0, 1'b1);
        check("mid_rst_data", data, 32'h0);
        check("mid_rst_vld", {31'b0, data_vld}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'hF, 1'b0, 1'b0);
            check("post_rst_hold", data, 32'h0);
        end
        send_frame(32'h3C3C_3C3C, 4'hF, 4'hF);
        check("clean_data", data, 32'h3C3C_3C3C);
        check("clean_vld", {31'b0, data_vld}, 32'h1);

        // Back-to-back strobe: sh now holds D6..D0 of 8'h3C plus the stop bit -> 8'h79.
        drive_cycle(4'hF, 1'b1, 1'b0);
        check("b2b_data", data, 32'h7979_7979);
        check("b2b_vld", {31'b0, data_vld}, 32'h1);

        // First strobe after release with only three zeros shifted in: 1111_1000.
        drive_cycle(4'hF, 1'b0, 1'b1);
        check("part_rst_data", data, 32'h0);
        drive_cycle(4'h0, 1'b0, 1'b0);
        drive_cycle(4'h0, 1'b0, 1'b0);
        drive_cycle(4'h0, 1'b0, 1'b0);
        drive_cycle(4'hF, 1'b1, 1'b0);
        check("partial_data", data, 32'hF8F8_F8F8);
        check("partial_vld", {31'b0, data_vld}, 32'h1);
        drive_cycle(4'hF, 1'b0, 1'b0);

`ifdef RX_FRAME_CHECK_EN
        // Bad stop bit on lane 2, then a clean frame clears the flag.
        send_frame(32'h1122_3344, 4'hF, 4'b1011);
        check("ferr_set", {28'b0, frame_err}, 32'h4);
        check("ferr_data", data, 32'h1122_3344);
        send_frame(32'h5566_7788, 4'hF, 4'hF);
        check("ferr_clear", {28'b0, frame_err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
